// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter that shares one AES-128 core between NREQ requesters.
// It runs the core's start/done handshake, routes the ciphertext back, and aborts a hung core.
module aes_core_arbiter #(
    parameter int NREQ           = 4,
    parameter int DW             = 128,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GW            = $clog2(NREQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*DW-1:0] req_key,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [DW-1:0]      resp_data,
    output logic               resp_err,
    output logic               core_encrypt,
    output logic [DW-1:0]      core_din,
    output logic [DW-1:0]      core_key,
    output logic               core_rst,
    input  logic               core_done,
    input  logic [DW-1:0]      core_dout,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);
    // Handshakes: a request transfers on the single IDLE cycle where req_valid[i] and
    // req_ready[i] are both high; a response transfers when resp_valid[g] and resp_ready[g] are high.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [GW-1:0] last_grant;
    logic [15:0]   wd;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          accept;
    logic          timeout;
    int            idx;

    // Cyclic search for the first requester after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = '0;
        resp_valid   = '0;
        core_encrypt = 1'b0;
        core_rst     = 1'b0;
        accept       = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found && !reset) begin
                    accept              = 1'b1;
                    req_ready[pick_idx] = 1'b1;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                core_encrypt = 1'b1;
                state_next   = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    state_next = RESP;
                end else if (wd == 16'(TIMEOUT_CYCLES - 1)) begin
                    core_rst   = 1'b1;
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GW'(NREQ - 1);
            grant_id   <= '0;
            core_din   <= '0;
            core_key   <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            wd         <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant_id <= pick_idx;
                core_din <= req_data[int'(pick_idx)*DW +: DW];
                core_key <= req_key[int'(pick_idx)*DW +: DW];
            end
            if (state == ISSUE) wd <= '0;
            else if (state == WAIT && !core_done) wd <= wd + 16'd1;
            // A done seen on the same cycle as the deadline still counts as success.
            if (state == WAIT && core_done) begin
                resp_data <= core_dout;
                resp_err  <= 1'b0;
            end else if (timeout) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
            if (state == RESP && resp_ready[grant_id]) last_grant <= grant_id;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: directed vectors, corner sequences and a randomized
// scoreboard run against a behavioural model of the arbitration rules and a mock core.
module tb_aes_core_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 128;
  localparam int TMO  = 16;
  localparam logic [DW-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*DW-1:0] req_data, req_key;
  logic [DW-1:0] resp_data, core_din, core_key, core_dout;
  logic resp_err, core_encrypt, core_rst, core_done, busy;
  logic [1:0] grant_id;

  logic [DW-1:0] d_data[NREQ];
  logic [DW-1:0] d_key[NREQ];
  int n_tests = 0;
  int n_fail = 0;
  int core_lat = 2;
  bit core_hang = 1'b0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [NREQ-1:0] valids;
    int              grant;
  } arb_vec_t;
  arb_vec_t tbl[12];

  aes_core_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_key(req_key), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .core_encrypt(core_encrypt), .core_din(core_din), .core_key(core_key), .core_rst(core_rst),
    .core_done(core_done), .core_dout(core_dout), .busy(busy), .grant_id(grant_id)
  );

  // clock / reset block
  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = d_data[i];
      req_key[i*DW +: DW]  = d_key[i];
    end
  end

  // Mock core: known FIPS-197 answer for the reference block, a keyed scramble otherwise.
  function automatic logic [DW-1:0] model_ct(input logic [DW-1:0] d, input logic [DW-1:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return (d ^ {k[63:0], k[127:64]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  int core_cnt;
  bit core_active;
  logic [DW-1:0] core_pend;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      core_done <= 1'b0;
      core_dout <= '0;
      core_active <= 1'b0;
      core_cnt <= 0;
    end else if (core_rst) begin
      core_done <= 1'b0;
      core_active <= 1'b0;
    end else if (core_encrypt) begin
      core_done <= 1'b0;
      core_active <= !core_hang;
      core_cnt <= core_lat;
      core_pend <= model_ct(core_din, core_key);
    end else if (core_active) begin
      if (core_cnt <= 1) begin
        core_done <= 1'b1;
        core_dout <= core_pend;
        core_active <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // Round-robin rule: first requesting index strictly after the last owner, wrapping.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic finish_txn(input int g, input logic [DW-1:0] exp_d, input logic exp_e, input string tag);
    int n;
    n = 0;
    resp_ready = '1;
    @(negedge clock);
    while (resp_valid == 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("%s resp_valid", tag), resp_valid, onehot(g));
    chk($sformatf("%s resp_data", tag), resp_data, exp_d);
    chk($sformatf("%s resp_err", tag), resp_err, exp_e);
    @(posedge clock); #1;
  endtask

  task automatic do_txn(input logic [NREQ-1:0] valids, input int exp_g, input string tag);
    int n;
    for (int i = 0; i < NREQ; i++) begin
      if (valids[i]) begin
        d_data[i] = {$urandom, $urandom, $urandom, $urandom};
        d_key[i]  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    req_valid = valids;
    n = 0;
    @(negedge clock);
    while (req_ready == 0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("%s grant", tag), req_ready, onehot(exp_g));
    @(posedge clock); #1;
    req_valid = '0;
    finish_txn(exp_g, model_ct(d_data[exp_g], d_key[exp_g]), 1'b0, tag);
  endtask

  // scoreboard state for the randomized run
  int m_last, m_owner, m_wait;
  bit m_busy;
  bit taken[NREQ];

  initial begin
    int n, p;
    bit gen;
    logic [NREQ-1:0] er;
    logic [DW-1:0] bp_exp;

    tbl[0]  = '{4'b0101, 0};
    tbl[1]  = '{4'b0101, 2};
    tbl[2]  = '{4'b0101, 0};
    tbl[3]  = '{4'b0101, 2};
    tbl[4]  = '{4'b1000, 3};
    tbl[5]  = '{4'b1001, 0};
    tbl[6]  = '{4'b0110, 1};
    tbl[7]  = '{4'b0110, 2};
    tbl[8]  = '{4'b1111, 3};
    tbl[9]  = '{4'b1111, 0};
    tbl[10] = '{4'b0010, 1};
    tbl[11] = '{4'b0001, 0};

    for (int i = 0; i < NREQ; i++) begin
      d_data[i] = '0;
      d_key[i]  = '0;
    end
    req_valid = '1;
    resp_ready = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset req_ready", req_ready, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset core_encrypt", core_encrypt, 0);
    chk("reset grant_id", grant_id, 0);
    @(posedge clock); #1;
    req_valid = '0;
    reset = 1'b0;

    // arbitration table, starting from last owner NREQ-1
    core_lat = 2;
    for (int v = 0; v < 12; v++) do_txn(tbl[v].valids, tbl[v].grant, $sformatf("tbl%0d", v));

    // FIPS-197 single request
    core_lat = 3;
    resp_ready = '0;
    d_data[0] = FIPS_PT;
    d_key[0] = FIPS_KEY;
    req_valid = 4'b0001;
    @(negedge clock);
    chk("fips req_ready", req_ready, 4'b0001);
    chk("fips no early encrypt", core_encrypt, 0);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk("fips encrypt", core_encrypt, 1);
    chk("fips core_din", core_din, FIPS_PT);
    chk("fips core_key", core_key, FIPS_KEY);
    chk("fips req_ready idle", req_ready, 0);
    @(negedge clock);
    chk("fips encrypt width", core_encrypt, 0);
    n = 0;
    while (!core_done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("fips resp before done sampled", resp_valid, 0);
    @(negedge clock);
    chk("fips resp_valid", resp_valid, 4'b0001);
    chk("fips resp_data", resp_data, FIPS_CT);
    chk("fips resp_err", resp_err, 0);
    @(posedge clock); #1;
    resp_ready = 4'b0001;
    @(negedge clock);
    chk("fips held", resp_valid, 4'b0001);
    @(posedge clock); #1;
    resp_ready = '0;
    @(negedge clock);
    chk("fips released", resp_valid, 0);
    chk("fips idle", busy, 0);

    // backpressure on requester 1, requester 0 waiting, stray resp_ready ignored
    core_lat = 2;
    resp_ready = 4'b1101;
    @(posedge clock); #1;
    d_data[1] = {$urandom, $urandom, $urandom, $urandom};
    d_key[1] = {$urandom, $urandom, $urandom, $urandom};
    bp_exp = model_ct(d_data[1], d_key[1]);
    req_valid = 4'b0010;
    @(negedge clock);
    chk("bp grant", req_ready, 4'b0010);
    @(posedge clock); #1;
    d_data[0] = {$urandom, $urandom, $urandom, $urandom};
    d_key[0] = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0001;
    n = 0;
    @(negedge clock);
    while (resp_valid == 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("bp resp_valid", resp_valid, 4'b0010);
      chk("bp resp_data", resp_data, bp_exp);
      chk("bp no grant", req_ready, 0);
    end
    @(posedge clock); #1;
    resp_ready = '1;
    @(negedge clock);
    chk("bp handshake no grant", req_ready, 0);
    chk("bp handshake valid", resp_valid, 4'b0010);
    @(negedge clock);
    chk("bp next grant", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    finish_txn(0, model_ct(d_data[0], d_key[0]), 1'b0, "bp req0");

    // watchdog timeout
    core_hang = 1'b1;
    d_data[2] = {$urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b0100;
    resp_ready = '0;
    @(negedge clock);
    chk("tmo grant", req_ready, 4'b0100);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    chk("tmo encrypt", core_encrypt, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!core_rst && n < 40);
    chk("tmo core_rst distance", n, TMO);
    @(negedge clock);
    chk("tmo core_rst width", core_rst, 0);
    chk("tmo resp_valid", resp_valid, 4'b0100);
    chk("tmo resp_data", resp_data, 0);
    chk("tmo resp_err", resp_err, 1);
    @(posedge clock); #1;
    resp_ready = '1;
    @(posedge clock); #1;
    core_hang = 1'b0;

    // reset in the middle of WAIT
    core_hang = 1'b1;
    req_valid = 4'b0010;
    @(negedge clock);
    chk("rst grant", req_ready, 4'b0010);
    @(posedge clock); #1;
    req_valid = '0;
    repeat (4) @(posedge clock);
    #1;
    req_valid = 4'b0011;
    reset = 1'b1;
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst resp_valid", resp_valid, 0);
    chk("rst resp_data", resp_data, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst core_encrypt", core_encrypt, 0);
    chk("rst core_din", core_din, 0);
    chk("rst core_key", core_key, 0);
    chk("rst core_rst", core_rst, 0);
    chk("rst busy", busy, 0);
    chk("rst grant_id", grant_id, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    core_hang = 1'b0;
    @(negedge clock);
    chk("rst first grant", req_ready, 4'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    finish_txn(0, model_ct(d_data[0], d_key[0]), 1'b0, "rst req0");

    // randomized run against the scoreboard
    m_last = 0;
    m_busy = 1'b0;
    m_owner = 0;
    m_wait = 0;
    for (int i = 0; i < NREQ; i++) taken[i] = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen = (cyc < 2850);
      @(posedge clock); #1;
      core_lat = $urandom_range(1, 8);
      for (int i = 0; i < NREQ; i++) begin
        if (taken[i]) begin
          req_valid[i] = 1'b0;
          taken[i] = 1'b0;
        end else if (!req_valid[i] && gen && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          d_data[i] = {$urandom, $urandom, $urandom, $urandom};
          d_key[i] = {$urandom, $urandom, $urandom, $urandom};
        end else if (req_valid[i] && (!gen || $urandom_range(0, 31) == 0)) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = gen ? NREQ'($urandom) : '1;
      @(negedge clock);
      chk("rnd busy", busy, m_busy);
      if (!m_busy) begin
        p = rr_pick(m_last, req_valid);
        er = (p >= 0) ? onehot(p) : '0;
        chk("rnd req_ready", req_ready, er);
        chk("rnd idle resp_valid", resp_valid, 0);
        if (p >= 0 && req_ready == er) begin
          exp_q.push_back(model_ct(d_data[p], d_key[p]));
          m_busy = 1'b1;
          m_owner = p;
          taken[p] = 1'b1;
          m_wait = 0;
        end
      end else begin
        m_wait++;
        chk("rnd busy req_ready", req_ready, 0);
        if (resp_valid != 0) begin
          chk("rnd resp_valid", resp_valid, onehot(m_owner));
          chk("rnd grant_id", grant_id, m_owner);
          chk("rnd resp_data", resp_data, (exp_q.size() > 0) ? exp_q[0] : '0);
          chk("rnd resp_err", resp_err, 0);
          if (resp_ready[m_owner]) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_last = m_owner;
            m_busy = 1'b0;
          end
        end else if (m_wait == 60) begin
          n_tests++;
          n_fail++;
          $display("FAIL rnd resp_wait: got no response after %0d cycles, expected one", m_wait);
        end
      end
    end
    chk("rnd drained queue", exp_q.size(), 0);
    chk("rnd drained busy", m_busy, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got no end of test, expected one");
    $fatal(1);
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES-128 encryption core between NREQ requesters, e.g. the PicoRV32 coprocessor port and a DMA engine.
- Arbitrates round-robin and latches the winner's plaintext and key.
- Sequences the core through its start/done handshake and returns the ciphertext to the granted requester.
- Includes a watchdog that resets the core and returns an error if it hangs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 128, block/key width in bits.
- TIMEOUT_CYCLES, 255, WAIT-state cycles before abort (1..65535).
- GW, $clog2(NREQ), grant index width (derived, not overridable).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  per-requester request.
- req_data  in  NREQ*DW  packed plaintexts; slice i belongs to requester i.
- req_key  in  NREQ*DW  packed keys.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  NREQ  one-hot response valid.
- resp_ready  in  NREQ  per-requester response accept.
- resp_data  out  DW  ciphertext, shared by all requesters.
- resp_err  out  1  response is a timeout error.
- core_encrypt  out  1  start pulse to core.
- core_din  out  DW  registered plaintext to core.
- core_key  out  DW  registered key to core.
- core_rst  out  1  synchronous abort pulse to core reset.
- core_done  in  1  core done level; held high until next start.
- core_dout  in  DW  core ciphertext; valid while core_done=1.
- busy  out  1  high in any state except IDLE.
- grant_id  out  GW  index of current owner.

Behaviour:
- Reset values: all outputs 0; internal last_grant=NREQ-1, so requester 0 wins first.
- Reset is honoured in any state; an in-flight transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit searching cyclically from last_grant+1.
  - Same cycle: req_ready[g]=1 (combinational, single cycle); latch req_data/req_key slice g into core_din/core_key; grant_id<=g; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: core_encrypt=1 for exactly one cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - On core_done=1: latch core_dout into resp_data, resp_err<=0, go to RESP.
  - Otherwise increment watchdog.
  - When watchdog reaches TIMEOUT_CYCLES-1 without done: core_rst=1 for one cycle, resp_data<=0, resp_err<=1, go to RESP.
  - Stale done from a previous transaction is impossible here: the core leaves its done state on the ISSUE edge.
- RESP:
  - resp_valid[grant_id]=1; resp_data and resp_err held stable.
  - On resp_ready[grant_id]=1: last_grant<=grant_id, resp_valid<=0, go to IDLE.
  - resp_ready of non-granted requesters is ignored.
  - No new grant is made in the cycle the response is accepted; the earliest next accept is the following cycle.
- Latency: accept at cycle T; core_encrypt at T+1; resp_valid the cycle after core_done is first sampled high.
- req_valid withdrawn before grant is legal; requests are never queued.
- Requester 0 and requester NREQ-1 requesting together after a grant to NREQ-1: requester 0 wins (wrap-around).
- core_din/core_key only change in IDLE on accept.

Test Plan:
- Single request, FIPS-197: req0 pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> req_ready[0] one cycle; core_encrypt one cycle later; resp_valid[0] with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0.
- Contention: req0 and req2 held valid continuously, resp_ready tied high -> grants 0,2,0,2; each response carries the matching ciphertext.
- Wrap-around: last grant=3 (NREQ=4), then req3 and req0 simultaneous -> grant 0.
- Backpressure: resp_ready[1] low for 20 cycles -> resp_valid[1] and resp_data stable; req0 valid throughout receives no req_ready until the cycle after the handshake.
- Timeout: TIMEOUT_CYCLES=16, core_done stuck low -> core_rst one pulse 16 cycles after core_encrypt; resp_err=1, resp_data=0.
- Reset mid-WAIT -> all outputs 0 same cycle; first post-reset contention of req1/req0 grants 0.
